// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master slice.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSFER = 2'd1,
    TRAIL    = 2'd2
  } state_t;

  localparam int unsigned CLK_DIV_DEFAULT = 4;
  localparam int unsigned DATA_W_DEFAULT  = 8;

endpackage

// File: rtl/spi_half_timer.sv
// Emits a one-cycle tick every CLK_DIV clk cycles while enabled; held cleared when disabled.
module spi_half_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(CLK_DIV - 1));

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one byte per start_tx, MSB first, with a one-half-period CS hold tail.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              start_tx,
  input  logic              miso,
  output logic              spi_clk,
  output logic              mosi,
  output logic              cs,
  output logic              tx_done,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy
);

  localparam int unsigned BIT_W = $clog2(DATA_W);

  state_t            state, state_next;
  logic              tick;
  logic              sclk_q;
  logic              done_q;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_q;
  logic [BIT_W-1:0]  bit_cnt;

  logic accept, rise, fall, last_fall, done_next;

  spi_half_timer #(.CLK_DIV(CLK_DIV)) u_half_timer (
    .clk   (clk),
    .reset (reset),
    .en    (state != IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    last_fall  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start_tx) begin
          accept     = 1'b1;
          state_next = TRANSFER;
        end
      end
      TRANSFER: begin
        if (tick) begin
          if (!sclk_q) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              last_fall  = 1'b1;
              state_next = TRAIL;
            end
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The final falling edge leaves tx_shift alone; the FSM moves to TRAIL instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_q     <= '0;
      bit_cnt  <= '0;
    end else begin
      done_q <= done_next;
      if (accept) begin
        tx_shift <= tx_data;
        rx_shift <= '0;
        bit_cnt  <= '0;
        sclk_q   <= 1'b0;
      end
      if (rise) begin
        sclk_q   <= 1'b1;
        rx_shift <= {rx_shift[DATA_W-2:0], miso};
      end
      if (fall) begin
        sclk_q <= 1'b0;
        if (!last_fall) begin
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          bit_cnt  <= bit_cnt + 1'b1;
        end
      end
      if (done_next) rx_q <= rx_shift;
    end
  end

  assign cs      = (state == IDLE);
  assign busy    = (state != IDLE);
  assign spi_clk = sclk_q;
  assign mosi    = (state != IDLE) && tx_shift[DATA_W-1];
  assign tx_done = done_q;
  assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master at CLK_DIV=4 (dut0) and CLK_DIV=1 (dut1).
module tb_spi_master;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data  [2];
  logic       start_tx [2];
  logic       miso     [2];
  logic       miso_val [2];
  logic       loop_en  [2];
  logic       spi_clk  [2];
  logic       mosi     [2];
  logic       cs       [2];
  logic       tx_done  [2];
  logic [7:0] rx_data  [2];
  logic       busy     [2];

  logic [7:0] model_rx [2];
  int n_cmp = 0;
  int n_bad = 0;

  spi_master #(.CLK_DIV(4), .DATA_W(8)) dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .start_tx(start_tx[0]),
    .miso(miso[0]), .spi_clk(spi_clk[0]), .mosi(mosi[0]), .cs(cs[0]),
    .tx_done(tx_done[0]), .rx_data(rx_data[0]), .busy(busy[0])
  );

  spi_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .start_tx(start_tx[1]),
    .miso(miso[1]), .spi_clk(spi_clk[1]), .mosi(mosi[1]), .cs(cs[1]),
    .tx_done(tx_done[1]), .rx_data(rx_data[1]), .busy(busy[1])
  );

  always_comb begin
    for (int i = 0; i < 2; i++) miso[i] = loop_en[i] ? mosi[i] : miso_val[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Idle cycles: outputs must sit at their idle values and rx_data must hold.
  task automatic idle(input int i, input int n);
    int e;
    e = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (cs[i] !== 1'b1 || busy[i] !== 1'b0 || tx_done[i] !== 1'b0 ||
          spi_clk[i] !== 1'b0 || mosi[i] !== 1'b0 || rx_data[i] !== model_rx[i]) e++;
    end
    check($sformatf("d%0d_idle_bad_cycles", i), e, 0);
  endtask

  // One transfer, accepted in the current cycle N. mode: 0 loopback, 1 random miso,
  // 2 miso=0, 3 miso=1. mid_at >= 0 pulses a competing start_tx (0x3C) at N+1+mid_at.
  task automatic xfer(input int i, input logic [7:0] tx, input int mode, input int mid_at);
    int h, k, rises;
    int e_cs, e_clk, e_mosi, e_busy, e_done, e_hold;
    logic [7:0] exp_rx;
    logic prev_clk, b, exp_clk, exp_mosi;
    h = (i == 0) ? 4 : 1;
    exp_rx = '0;
    rises = 0; prev_clk = 1'b0;
    e_cs = 0; e_clk = 0; e_mosi = 0; e_busy = 0; e_done = 0; e_hold = 0;
    loop_en[i]  = (mode == 0);
    start_tx[i] = 1'b1;
    tx_data[i]  = tx;
    for (int t = 0; t <= 17 * h; t++) begin
      @(negedge clk);
      start_tx[i] = 1'b0;
      tx_data[i]  = 8'($urandom);
      if (t == mid_at) begin
        start_tx[i] = 1'b1;
        tx_data[i]  = 8'h3C;
      end
      if (t < 17 * h) begin
        k = t / (2 * h);
        if (k > 7) k = 7;
        exp_clk  = (t < 16 * h) ? (((t / h) % 2) == 1) : 1'b0;
        exp_mosi = tx[7-k];
        if (cs[i] !== 1'b0)          e_cs++;
        if (busy[i] !== 1'b1)        e_busy++;
        if (tx_done[i] !== 1'b0)     e_done++;
        if (spi_clk[i] !== exp_clk)  e_clk++;
        if (mosi[i] !== exp_mosi)    e_mosi++;
        if (rx_data[i] !== model_rx[i]) e_hold++;
      end else begin
        check($sformatf("d%0d_done_cs", i), cs[i], 1);
        check($sformatf("d%0d_done_pulse_at_17H", i), tx_done[i], 1);
        check($sformatf("d%0d_done_busy", i), busy[i], 0);
        check($sformatf("d%0d_done_mosi", i), mosi[i], 0);
        check($sformatf("d%0d_done_sclk", i), spi_clk[i], 0);
        check($sformatf("d%0d_rx_data_tx%02h", i, tx), rx_data[i], exp_rx);
      end
      if (spi_clk[i] === 1'b1 && prev_clk === 1'b0) rises++;
      prev_clk = spi_clk[i];
      b = (mode == 2) ? 1'b0 : (mode == 3) ? 1'b1 : 1'($urandom);
      miso_val[i] = b;
      if (((t + 1) % (2 * h)) == h && (t + 1) < 16 * h)
        exp_rx = {exp_rx[6:0], (mode == 0) ? tx[7-((t+1)/(2*h))] : b};
    end
    model_rx[i] = exp_rx;
    check($sformatf("d%0d_cs_low_errs", i), e_cs, 0);
    check($sformatf("d%0d_busy_errs", i), e_busy, 0);
    check($sformatf("d%0d_early_done_errs", i), e_done, 0);
    check($sformatf("d%0d_sclk_wave_errs", i), e_clk, 0);
    check($sformatf("d%0d_mosi_stream_errs", i), e_mosi, 0);
    check($sformatf("d%0d_rx_hold_errs", i), e_hold, 0);
    check($sformatf("d%0d_rising_edges", i), rises, 8);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      tx_data[i] = 8'hFF; start_tx[i] = 1'b1; miso_val[i] = 1'b1;
      loop_en[i] = 1'b0; model_rx[i] = '0;
    end
    reset = 1'b1;
    // start_tx held during reset must not be accepted
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d_rst_cs", i), cs[i], 1);
      check($sformatf("d%0d_rst_busy", i), busy[i], 0);
      check($sformatf("d%0d_rst_sclk", i), spi_clk[i], 0);
      check($sformatf("d%0d_rst_mosi", i), mosi[i], 0);
      check($sformatf("d%0d_rst_done", i), tx_done[i], 0);
      check($sformatf("d%0d_rst_rx", i), rx_data[i], 8'h00);
      start_tx[i] = 1'b0;
    end
    reset = 1'b0;
    idle(0, 2);
    idle(1, 1);

    // Loopback at H=4 and H=1
    xfer(0, 8'hA5, 0, -1);
    idle(0, 2);
    xfer(1, 8'hC3, 0, -1);
    idle(1, 2);

    // Constant miso levels
    xfer(0, 8'hFF, 2, -1);
    idle(0, 1);
    xfer(0, 8'h00, 3, -1);
    idle(0, 1);

    // Competing start_tx mid-transfer is ignored
    xfer(0, 8'h81, 1, 20);
    idle(0, 6);

    // Back-to-back: new start in the tx_done cycle
    xfer(0, 8'h11, 0, -1);
    xfer(0, 8'h5A, 0, -1);
    idle(0, 2);

    // Reset on the 4th spi_clk rising edge aborts the transfer
    loop_en[0]  = 1'b1;
    start_tx[0] = 1'b1;
    tx_data[0]  = 8'h96;
    for (int t = 0; t <= 28; t++) begin
      @(negedge clk);
      start_tx[0] = 1'b0;
      if (t == 28) begin
        check("d0_abort_sclk_high_at_rise4", spi_clk[0], 1);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    check("d0_abort_cs", cs[0], 1);
    check("d0_abort_sclk", spi_clk[0], 0);
    check("d0_abort_mosi", mosi[0], 0);
    check("d0_abort_done", tx_done[0], 0);
    check("d0_abort_busy", busy[0], 0);
    check("d0_abort_rx", rx_data[0], 8'h00);
    model_rx[0] = '0;
    model_rx[1] = '0;
    idle(0, 80);
    idle(1, 1);
    xfer(0, 8'h69, 0, -1);
    idle(0, 1);

    // Randomized transfers on both instances, with random gaps (0 = chained)
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 2; i++) begin
        int gap;
        xfer(i, 8'($urandom), int'($urandom_range(0, 3)), -1);
        gap = int'($urandom_range(0, 2));
        if (gap > 0) idle(i, gap);
        else xfer(i, 8'($urandom), int'($urandom_range(0, 3)), -1);
        idle(i, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
